// File: rtl/fsm_seq_driver_pkg.sv
// rtl/fsm_seq_driver_pkg.sv - shared encodings and Moore output lookup for the sequence driver
package fsm_seq_driver_pkg;

    typedef enum logic [1:0] {
        S_A = 2'b00,
        S_B = 2'b01,
        S_C = 2'b10,
        S_D = 2'b11
    } core_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } ctl_state_t;

    function automatic logic core_y(input core_state_t s);
        return (s == S_B) || (s == S_C);
    endfunction

endpackage

// File: rtl/fsm_seq_core.sv
// rtl/fsm_seq_core.sv - 4-state Moore core with step enable and synchronous load-to-A
module fsm_seq_core
    import fsm_seq_driver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic       x,
    output logic [1:0] state,
    output logic       step_y,
    output logic       step_is_d
);

    core_state_t state_q, state_d, step_s;

    always_comb begin
        step_s = state_q;
        case (state_q)
            S_A: step_s = x ? S_C : S_B;
            S_B: step_s = x ? S_D : S_C;
            S_C: step_s = x ? S_D : S_B;
            S_D: step_s = x ? S_A : S_C;
            default: step_s = S_A;
        endcase
        state_d = state_q;
        if (load)
            state_d = S_A;
        else if (en)
            state_d = step_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_A;
        else
            state_q <= state_d;
    end

    // The driver records the state the core is about to enter, so expose it pre-edge.
    assign state     = state_q;
    assign step_y    = core_y(step_s);
    assign step_is_d = (step_s == S_D);

endmodule

// File: rtl/fsm_seq_driver.sv
// rtl/fsm_seq_driver.sv - start/busy/done stimulus and trace engine around the Moore core
module fsm_seq_driver
    import fsm_seq_driver_pkg::*;
#(
    parameter int LEN = 8,
    parameter int CW  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [LEN-1:0] pat_in,
    input  logic [CW-1:0]  pat_len,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           x_out,
    output logic [1:0]     state_out,
    output logic [LEN-1:0] y_trace,
    output logic [CW-1:0]  visit_d
);

    ctl_state_t     ctl_q, ctl_d;
    logic [LEN-1:0] pat_q;
    logic [LEN-1:0] trace_d;
    logic [CW-1:0]  len_q, idx_q, idx_d;
    logic           len_ok, load_go, step, last_step;
    logic           step_y, step_is_d, x_d;

    assign len_ok    = (pat_len != '0) && (pat_len <= CW'(LEN));
    assign load_go   = (ctl_q == IDLE) && start && len_ok;
    assign step      = (ctl_q == RUN) && !abort;
    assign last_step = (idx_q == len_q - CW'(1));

    always_comb begin
        ctl_d = ctl_q;
        case (ctl_q)
            IDLE: if (load_go) ctl_d = LOAD;
            LOAD: ctl_d = abort ? IDLE : RUN;
            RUN:  if (abort) ctl_d = IDLE;
                  else if (last_step) ctl_d = DONE;
            DONE: ctl_d = IDLE;
            default: ctl_d = IDLE;
        endcase

        idx_d = idx_q;
        if (load_go)
            idx_d = '0;
        else if (step)
            idx_d = idx_q + CW'(1);

        // x_out is registered, so select the bit for the step that will run next cycle.
        x_d = 1'b0;
        for (int i = 0; i < LEN; i++)
            if (ctl_d == RUN && CW'(i) == idx_d)
                x_d = pat_q[i];

        trace_d = y_trace;
        for (int i = 0; i < LEN; i++)
            if (CW'(i) == idx_q)
                trace_d[i] = step_y;
    end

    fsm_seq_core u_core (
        .clk       (clk),
        .reset     (reset),
        .en        (step),
        .load      (load_go),
        .x         (x_out),
        .state     (state_out),
        .step_y    (step_y),
        .step_is_d (step_is_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_q   <= IDLE;
            idx_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            x_out   <= 1'b0;
            y_trace <= '0;
            visit_d <= '0;
        end else begin
            ctl_q <= ctl_d;
            idx_q <= idx_d;
            busy  <= (ctl_d == LOAD) || (ctl_d == RUN);
            done  <= (ctl_d == DONE);
            err   <= (ctl_q == IDLE) && start && !len_ok;
            x_out <= x_d;
            if (load_go) begin
                pat_q   <= pat_in;
                len_q   <= pat_len;
                y_trace <= '0;
                visit_d <= '0;
            end else if (step) begin
                y_trace <= trace_d;
                if (step_is_d)
                    visit_d <= visit_d + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fsm_seq_driver.sv
// tb/tb_fsm_seq_driver.sv - self-checking bench for fsm_seq_driver against a behavioural model
module tb_fsm_seq_driver;

    localparam int LEN = 8;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [LEN-1:0] pat_in = '0;
    logic [CW-1:0]  pat_len = '0;
    logic           busy, done, err, x_out;
    logic [1:0]     state_out;
    logic [LEN-1:0] y_trace;
    logic [CW-1:0]  visit_d;

    fsm_seq_driver #(.LEN(LEN), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .pat_in    (pat_in),
        .pat_len   (pat_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .x_out     (x_out),
        .state_out (state_out),
        .y_trace   (y_trace),
        .visit_d   (visit_d)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: transition table indexed by state*2+x (A=0,B=1,C=2,D=3) and Moore output table.
    int         nxt_tab[8] = '{1, 2, 2, 3, 1, 3, 2, 0};
    int         y_tab[4]   = '{0, 1, 1, 0};
    int         m_t = 0;
    int         m_len = 0;
    int         m_steps = 0;
    logic [7:0] m_pat = '0;
    int         m_path[8];
    logic       m_err = 1'b0;

    // m_t counts cycles since the accepted start (1 = load, 2..len+1 = steps, len+2 = done).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t = 0;
            m_len = 0;
            m_steps = 0;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_t == 0) begin
                if (start) begin
                    if (pat_len >= 1 && pat_len <= LEN) begin
                        int cur;
                        m_pat = pat_in;
                        m_len = int'(pat_len);
                        m_steps = 0;
                        m_t = 1;
                        cur = 0;
                        for (int i = 0; i < m_len; i++) begin
                            cur = nxt_tab[cur*2 + int'(m_pat[i])];
                            m_path[i] = cur;
                        end
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end else if (m_t == m_len + 2) begin
                m_t = 0;
            end else if (abort) begin
                m_t = 0;
            end else begin
                if (m_t >= 2)
                    m_steps++;
                m_t++;
            end
        end
    end

    always @(negedge clk) begin
        logic       e_busy, e_done, e_x;
        logic [1:0] e_state;
        logic [7:0] e_trace;
        int         e_vis;
        e_busy  = (m_t >= 1) && (m_t <= m_len + 1);
        e_done  = (m_t != 0) && (m_t == m_len + 2);
        e_x     = (m_t >= 2 && m_t <= m_len + 1) ? m_pat[m_t-2] : 1'b0;
        e_state = (m_steps == 0) ? 2'd0 : 2'(m_path[m_steps-1]);
        e_trace = '0;
        e_vis   = 0;
        for (int i = 0; i < m_steps; i++) begin
            e_trace[i] = y_tab[m_path[i]][0];
            if (m_path[i] == 3)
                e_vis++;
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(m_err));
        chk("x_out", 32'(x_out), 32'(e_x));
        chk("state_out", 32'(state_out), 32'(e_state));
        chk("y_trace", 32'(y_trace), 32'(e_trace));
        chk("visit_d", 32'(visit_d), 32'(e_vis));
    end

    task automatic run_dir(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] exp_tr, input int exp_v, input logic [1:0] exp_st);
        int  cyc;
        logic got;
        @(posedge clk); #1;
        pat_in = p;
        pat_len = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done)
                got = 1'b1;
        end
        chk("done_cycle", got ? 32'(cyc) : 32'd0, 32'(l) + 32'd2);
        chk("lit_trace", 32'(y_trace), 32'(exp_tr));
        chk("lit_visit", 32'(visit_d), 32'(exp_v));
        chk("lit_state", 32'(state_out), 32'(exp_st));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_trace", 32'(y_trace), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset held for 3 cycles mid-run.
        pat_in = 8'hA5;
        pat_len = 4'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_trace", 32'(y_trace), 32'd0);
        chk("midrst_visit", 32'(visit_d), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_dir(8'h00, 4'd4, 8'h0F, 0, 2'b10);
        run_dir(8'h0F, 4'd4, 8'h09, 1, 2'b10);
        run_dir(8'h06, 4'd4, 8'h09, 1, 2'b01);

        // Invalid lengths: err pulses once per start, nothing else moves.
        @(posedge clk); #1;
        pat_len = 4'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_len0", 32'(err), 32'd1);
        chk("err_len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_len0_pulse", 32'(err), 32'd0);
        @(posedge clk); #1;
        pat_len = 4'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_len9", 32'(err), 32'd1);
        chk("err_len9_busy", 32'(busy), 32'd0);
        chk("err_trace_kept", 32'(y_trace), 32'h09);

        // Abort in the 3rd run cycle; a start during the run is ignored.
        @(posedge clk); #1;
        pat_in = 8'hFF;
        pat_len = 4'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_trace", 32'(y_trace), 32'h01);
        chk("abort_visit", 32'(visit_d), 32'd1);
        chk("abort_state", 32'(state_out), 32'd3);

        run_dir(8'hFF, 4'd8, 8'h49, 3, 2'b11);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = ($urandom % 5) == 0;
            abort = ($urandom % 12) == 0;
            if (($urandom % 3) == 0)
                pat_in = 8'($urandom);
            if (($urandom % 4) == 0)
                pat_len = 4'($urandom_range(0, 10));
            reset = ($urandom % 400) != 0;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
